mem_burst_master: RTL
=====================

Name: mem_burst_master

Overview:
- Request generator directly upstream of the memory block.
- Accepts one burst command (write or read, start address, beat count, data seed).
- Expands the command into single-beat valid/ready transactions on the memory's request port.
- Returns read beats on a one-cycle-valid stream and flags a stalled memory via a ready watchdog.

Parameters:
WIDTH, 16, data width of memory words and seed
ADDR_WIDTH, 4, memory address width
DEPTH, 16, number of memory words; address wraps modulo DEPTH
LEN_WIDTH, 5, width of the burst beat count
TIMEOUT, 16, max cycles mem_valid_o may wait for mem_ready_i before abort

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  reset, synchronous, active-high
cmd_valid_i  input  1  burst command valid
cmd_ready_o  output  1  command accepted when cmd_valid_i && cmd_ready_o
cmd_wr_i  input  1  1=write burst, 0=read burst
cmd_addr_i  input  ADDR_WIDTH  start address
cmd_len_i  input  LEN_WIDTH  number of beats (0 allowed)
cmd_wdata_i  input  WIDTH  write seed; beat k writes seed+k
mem_valid_o  output  1  request valid to memory (drives memory valid_i)
mem_wr_rd_o  output  1  1=write, 0=read (drives memory wr_rd_en_i)
mem_addr_o  output  ADDR_WIDTH  beat address (drives memory addr_i)
mem_wdata_o  output  WIDTH  beat write data (drives memory wdata_i)
mem_ready_i  input  1  memory ready (from memory ready_o)
mem_rdata_i  input  WIDTH  memory read data (from memory rdata_o)
rd_valid_o  output  1  one-cycle pulse, read beat available
rd_data_o  output  WIDTH  read beat data
busy_o  output  1  burst in progress (state != IDLE)
done_o  output  1  one-cycle pulse at burst end
err_o  output  1  sticky timeout flag; cleared on next command accept

Behaviour:
- Reset: synchronous, active-high. All outputs 0 except cmd_ready_o=1; state=IDLE.
- Reset mid-burst abandons the burst: mem_valid_o=0 at the next edge, no done_o.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On accept, latch wr, addr, len and seed; clear beat counter, watchdog and err_o.
  - len==0 -> DONE; else -> REQ.
- REQ:
  - cmd_ready_o=0, mem_valid_o=1.
  - mem_wr_rd_o, mem_addr_o and mem_wdata_o stay stable until the handshake (mem_valid_o && mem_ready_i).
- On each handshake:
  - Address = (addr==DEPTH-1) ? 0 : addr+1.
  - Data = data+1, mod 2^WIDTH.
  - Beat count increments; watchdog clears.
- Read handshake: rdata is sampled in the handshake cycle; rd_data_o<=mem_rdata_i and rd_valid_o=1 for exactly one cycle after it. There is no backpressure on the rd stream.
- Last-beat handshake -> DONE; mem_valid_o=0 the following cycle.
  - Back-to-back beats are allowed when mem_ready_i is held high: 1 beat per cycle.
- Watchdog:
  - Counts cycles in REQ with mem_ready_i=0.
  - When it reaches TIMEOUT: err_o<=1, mem_valid_o drops, -> DONE.
  - Remaining beats are skipped.
- DONE: done_o=1 for one cycle, busy_o=1, -> IDLE. cmd_ready_o returns to 1 the cycle after DONE.
- A command presented during REQ/DONE is held off (cmd_ready_o=0) and is not lost.
- Latency:
  - cmd accept -> mem_valid_o high: 1 cycle.
  - N-beat burst with ready always high: accept to done_o = N+1 cycles.

Test Plan:
- Write burst: wr=1, addr=2, len=4, seed=0x00A0, ready tied high -> beats addr 2,3,4,5 with data A0..A3 on 4 consecutive cycles; done_o pulses once; err_o=0.
- Read back: wr=0, addr=2, len=4 against the memory DUT -> rd_valid_o pulses 4 times with rd_data_o=A0,A1,A2,A3.
- Wrap and stall:
  - wr=1, addr=14, len=4, seed=0xFFFE -> addresses 14,15,0,1; data FFFE,FFFF,0000,0001.
  - With mem_ready_i toggling 1-0-1-0, each request stays stable while ready is low.
- Zero length and holdoff:
  - len=0 -> no mem_valid_o; done_o 1 cycle after accept.
  - A second command held during busy is accepted only after IDLE.
- Timeout: mem_ready_i stuck 0, len=3 -> after 16 wait cycles err_o=1, done_o pulses, no handshakes; next command accept clears err_o.
- Reset mid-burst: rst_i=1 at beat 2 of 4 -> next edge mem_valid_o=0, busy_o=0, cmd_ready_o=1, no done_o.

Source files
------------

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - expands one burst command into single-beat memory requests
// Read beats return on a one-cycle pulse stream; a ready watchdog aborts a stalled burst.
module mem_burst_master #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int LEN_WIDTH  = 5,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic [WIDTH-1:0]      cmd_wdata_i,
    output logic                  mem_valid_o,
    output logic                  mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    output logic                  rd_valid_o,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic [LEN_WIDTH-1:0]   beat_next;
    logic [WD_W-1:0]        wdog;
    logic                   handshake;

    assign handshake = mem_valid_o && mem_ready_i;
    assign beat_next = beat_cnt + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            mem_valid_o <= 1'b0;
            mem_wr_rd_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            len_q       <= '0;
            beat_cnt    <= '0;
            wdog        <= '0;
        end else begin
            rd_valid_o <= 1'b0;
            done_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        mem_wr_rd_o <= cmd_wr_i;
                        mem_addr_o  <= cmd_addr_i;
                        mem_wdata_o <= cmd_wdata_i;
                        len_q       <= cmd_len_i;
                        beat_cnt    <= '0;
                        wdog        <= '0;
                        err_o       <= 1'b0;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (cmd_len_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state       <= REQ;
                            mem_valid_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (handshake) begin
                        mem_addr_o  <= (mem_addr_o == ADDR_WIDTH'(DEPTH - 1)) ? '0 : mem_addr_o + 1'b1;
                        mem_wdata_o <= mem_wdata_o + 1'b1;
                        beat_cnt    <= beat_next;
                        wdog        <= '0;
                        if (!mem_wr_rd_o) begin
                            rd_data_o  <= mem_rdata_i;
                            rd_valid_o <= 1'b1;
                        end
                        if (beat_next == len_q) begin
                            mem_valid_o <= 1'b0;
                            state       <= DONE;
                            done_o      <= 1'b1;
                        end
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        // Stalled too long: abandon the remaining beats
                        err_o       <= 1'b1;
                        mem_valid_o <= 1'b0;
                        state       <= DONE;
                        done_o      <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    cmd_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_o <= 1'b1;
                    mem_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
